// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register addresses,
// STATUS/CTRL bit positions and bus FSM state encodings.
package uart_pkg;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  // STATUS/CTRL register bit positions; count occupies bits [8:4]
  localparam int ST_NE      = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_ACT     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_EN      = 16;
  localparam int ST_IE      = 17;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive character FIFO: power-of-two storage with wrapping pointers and an
// occupancy count one bit wider than the pointers.
module uart_rx_fifo #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BITS-1:0]          wdata,
  output logic [BITS-1:0]          rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  // NOTE: storage is deliberately left out of reset; it is never read while
  // empty, and a reset-free array maps onto plain RAM/flops without a clear.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: FIFO-buffered characters behind a two-register bus
// slave. Optional interrupt output is built only when UART_RX_IRQ_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst,
  input  logic            i_rx_done,
  input  logic [BITS-1:0] i_rx_data,
  input  logic            i_rx_active,
  input  logic            i_wb_cyc,
  input  logic            i_wb_we,
  input  logic            i_wb_adr,
  input  logic [31:0]     i_wb_dat,
  output logic [31:0]     o_wb_rdt,
  output logic            o_wb_ack,
  output logic            o_irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_e      state_q;
  bus_state_e      state_d;
  logic            fire;
  logic            rd_pop;
  logic            wr_ctrl;
  logic            rx_push;
  logic            ovr_set;
  logic            en_q;
  logic            ovr_q;
  logic            ie;
  logic [31:0]     rd_val;
  logic [31:0]     rdt_q;

  logic [BITS-1:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  uart_rx_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_wb_clk),
    .rst   (i_wb_rst),
    .push  (rx_push),
    .pop   (rd_pop),
    .wdata (i_rx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; combinational blocks use blocking assignment.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) state_q <= BUS_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: defaults are assigned first so no path leaves state_d unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (i_wb_cyc) state_d = BUS_ACK;
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Side effects happen only on the IDLE->ACK edge, once per request.
  assign fire     = (state_q == BUS_IDLE) && i_wb_cyc;
  assign o_wb_ack = (state_q == BUS_ACK);
  assign rd_pop   = fire && !i_wb_we && (i_wb_adr == ADR_DATA) && !fifo_empty;
  assign wr_ctrl  = fire && i_wb_we && (i_wb_adr == ADR_STATUS);

  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign rx_push = i_rx_done && en_q && (!fifo_full || rd_pop);
  assign ovr_set = i_rx_done && en_q && fifo_full && !rd_pop;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      en_q  <= 1'b1;
      ovr_q <= 1'b0;
    end else begin
      if (wr_ctrl) en_q <= i_wb_dat[ST_EN];
      if (ovr_set)                         ovr_q <= 1'b1;
      else if (wr_ctrl && i_wb_dat[ST_OVR]) ovr_q <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    if (i_wb_adr == ADR_DATA) begin
      if (!fifo_empty) rd_val[BITS-1:0] = fifo_rdata;
    end else begin
      rd_val[ST_NE]               = !fifo_empty;
      rd_val[ST_FULL]             = fifo_full;
      rd_val[ST_OVR]              = ovr_q;
      rd_val[ST_ACT]              = i_rx_active;
      rd_val[ST_CNT_LSB +: CW]    = fifo_count;
      rd_val[ST_EN]               = en_q;
      rd_val[ST_IE]               = ie;
    end
  end

  // Loaded on the edge into ACK and cleared on every other edge, so the bus
  // sees zero whenever ack is low.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst)              rdt_q <= '0;
    else if (fire && !i_wb_we) rdt_q <= rd_val;
    else                       rdt_q <= '0;
  end

  assign o_wb_rdt = rdt_q;

`ifdef UART_RX_IRQ_EN
  logic ie_q;
  logic irq_q;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= i_wb_dat[ST_IE];
      irq_q <= ie_q && (!fifo_empty || ovr_q);
    end
  end

  assign ie    = ie_q;
  assign o_irq = irq_q;

  logic unused_dat;
  assign unused_dat = ^{i_wb_dat[31:18], i_wb_dat[15:3], i_wb_dat[1:0]};
`else
  assign ie    = 1'b0;
  assign o_irq = 1'b0;

  logic unused_dat;
  assign unused_dat = ^{i_wb_dat[31:17], i_wb_dat[15:3], i_wb_dat[1:0]};
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios followed by random
// traffic compared against a queue-based model. Honours UART_RX_IRQ_EN.
module tb_uart_rx_ctrl;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_done;
  logic [BITS-1:0] rx_data;
  logic            rx_active;
  logic            cyc;
  logic            we;
  logic            adr;
  logic [31:0]     dat;
  logic [31:0]     rdt;
  logic            ack;
  logic            irq;

  uart_rx_ctrl #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) dut (
    .i_wb_clk    (clk),
    .i_wb_rst    (rst),
    .i_rx_done   (rx_done),
    .i_rx_data   (rx_data),
    .i_rx_active (rx_active),
    .i_wb_cyc    (cyc),
    .i_wb_we     (we),
    .i_wb_adr    (adr),
    .i_wb_dat    (dat),
    .o_wb_rdt    (rdt),
    .o_wb_ack    (ack),
    .o_irq       (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [BITS-1:0] q[$];
  bit m_ovr;
  bit m_en;
  bit m_ie;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] r;
    r       = '0;
    r[0]    = (q.size() != 0);
    r[1]    = (q.size() == DEPTH);
    r[2]    = m_ovr;
    r[3]    = rx_active;
    r[8:4]  = 5'(q.size());
    r[16]   = m_en;
    r[17]   = m_ie;
    return r;
  endfunction

  function automatic logic exp_irq();
    return HAS_IRQ && m_ie && ((q.size() != 0) || m_ovr);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 1'b0;
    m_en  = 1'b1;
    m_ie  = 1'b0;
  endtask

  task automatic pulse(input logic [BITS-1:0] d);
    rx_done = 1'b1;
    rx_data = d;
    tick();
    rx_done = 1'b0;
    if (m_en) begin
      if (q.size() < DEPTH) q.push_back(d);
      else                  m_ovr = 1'b1;
    end
  endtask

  // One bus request, optionally with a coincident receiver pulse.
  task automatic bus_op(input string tag, input bit w, input bit a, input logic [31:0] d,
                        input bit rx, input logic [BITS-1:0] rxd, output logic [31:0] got);
    logic [31:0] exp_rdt;
    bit full_b, popped, set_ovr;
    int n;
    exp_rdt = '0;
    full_b  = (q.size() == DEPTH);
    popped  = 1'b0;
    set_ovr = 1'b0;
    if (!w) begin
      if (!a) begin
        if (q.size() != 0) exp_rdt = 32'(q[0]);
      end else begin
        exp_rdt = exp_status();
      end
    end
    cyc = 1'b1; we = w; adr = a; dat = d;
    rx_done = rx; rx_data = rxd;
    tick();
    rx_done = 1'b0;
    n = 0;
    while (!ack && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_ack"}, 32'(ack), 32'd1);
    got = rdt;
    cyc = 1'b0; we = 1'b0; dat = '0;
    if (!w) check(tag, got, exp_rdt);
    if (!w && !a && q.size() != 0) begin
      void'(q.pop_front());
      popped = 1'b1;
    end
    if (rx && m_en) begin
      if (!full_b || popped) q.push_back(rxd);
      else                   set_ovr = 1'b1;
    end
    if (w && a) begin
      if (d[2]) m_ovr = 1'b0;
      m_en = d[16];
      m_ie = HAS_IRQ ? d[17] : 1'b0;
    end
    if (set_ovr) m_ovr = 1'b1;
    tick();
    check({tag, "_ack_once"}, 32'(ack), 32'd0);
    check({tag, "_rdt_idle"}, rdt, 32'd0);
  endtask

  task automatic irq_check(input string tag);
    tick();
    check(tag, 32'(irq), 32'(exp_irq()));
  endtask

  logic [31:0] got;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = '0; rx_active = 1'b0;
    cyc = 1'b0; we = 1'b0; adr = 1'b0; dat = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdt", rdt, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    bus_op("rst_status", 1'b0, 1'b1, '0, 1'b0, '0, got);
    check("rst_status_const", got, 32'h0001_0000);

    // Three characters in order
    pulse(8'h41); pulse(8'h42); pulse(8'h43);
    bus_op("fifo_rd0", 1'b0, 1'b0, '0, 1'b0, '0, got); check("fifo_rd0_c", got, 32'h41);
    bus_op("fifo_rd1", 1'b0, 1'b0, '0, 1'b0, '0, got); check("fifo_rd1_c", got, 32'h42);
    bus_op("fifo_rd2", 1'b0, 1'b0, '0, 1'b0, '0, got); check("fifo_rd2_c", got, 32'h43);
    bus_op("fifo_st", 1'b0, 1'b1, '0, 1'b0, '0, got);
    check("fifo_ne0", 32'(got[0]), 32'd0);
    check("fifo_cnt0", 32'(got[8:4]), 32'd0);

    // Overflow with five characters into a four-entry FIFO
    for (int i = 0; i < 5; i++) pulse(8'(8'h10 + i));
    bus_op("ovr_st", 1'b0, 1'b1, '0, 1'b0, '0, got);
    check("ovr_full", 32'(got[1]), 32'd1);
    check("ovr_set", 32'(got[2]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus_op("ovr_rd", 1'b0, 1'b0, '0, 1'b0, '0, got);
      check("ovr_rd_c", got, 32'(8'h10 + i));
    end
    bus_op("ovr_clr", 1'b1, 1'b1, 32'h4, 1'b0, '0, got);
    bus_op("ovr_st2", 1'b0, 1'b1, '0, 1'b0, '0, got);
    check("ovr_clr_c", 32'(got[2]), 32'd0);
    bus_op("reen", 1'b1, 1'b1, 32'h0001_0000, 1'b0, '0, got);

    // Full FIFO with a pop coincident with a new character
    for (int i = 0; i < 4; i++) pulse(8'(8'h20 + i));
    bus_op("pp_rd", 1'b0, 1'b0, '0, 1'b1, 8'h24, got);
    check("pp_rd_c", got, 32'h20);
    bus_op("pp_st", 1'b0, 1'b1, '0, 1'b0, '0, got);
    check("pp_ovr", 32'(got[2]), 32'd0);
    check("pp_cnt", 32'(got[8:4]), 32'd4);
    for (int i = 1; i < 5; i++) begin
      bus_op("pp_drain", 1'b0, 1'b0, '0, 1'b0, '0, got);
      check("pp_drain_c", got, 32'(8'h20 + i));
    end

    // Empty read and disabled receiver
    bus_op("empty_rd", 1'b0, 1'b0, '0, 1'b0, '0, got);
    check("empty_rd_c", got, 32'd0);
    bus_op("dis", 1'b1, 1'b1, 32'h0, 1'b0, '0, got);
    pulse(8'h55);
    bus_op("dis_st", 1'b0, 1'b1, '0, 1'b0, '0, got);
    check("dis_cnt", 32'(got[8:4]), 32'd0);
    bus_op("dis_reen", 1'b1, 1'b1, 32'h0001_0000, 1'b0, '0, got);

    // Interrupt: asserts a cycle after data arrives, drops after the pop
    bus_op("ie_set", 1'b1, 1'b1, 32'h0003_0000, 1'b0, '0, got);
    pulse(8'h66);
    tick();
    check("irq_on", 32'(irq), 32'(HAS_IRQ));
    bus_op("irq_rd", 1'b0, 1'b0, '0, 1'b0, '0, got);
    check("irq_off", 32'(irq), 32'd0);

    // Reset in the middle of an acknowledged read
    pulse(8'h71); pulse(8'h72);
    cyc = 1'b1; we = 1'b0; adr = 1'b0;
    tick();
    check("mid_ack", 32'(ack), 32'd1);
    rst = 1'b1; cyc = 1'b0; rx_done = 1'b1; rx_data = 8'h73;
    tick();
    rst = 1'b0; rx_done = 1'b0;
    model_reset();
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_rdt", rdt, 32'd0);
    bus_op("mid_rst_st", 1'b0, 1'b1, '0, 1'b0, '0, got);
    check("mid_rst_st_c", got, 32'h0001_0000);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      int op;
      logic [31:0] wd;
      rx_active = 1'($urandom);
      irq_check("rnd_irq");
      op = int'($urandom_range(0, 5));
      wd = $urandom;
      wd[16] = ($urandom_range(0, 3) != 0);
      case (op)
        0, 1: pulse(BITS'($urandom));
        2: bus_op("rnd_rd", 1'b0, 1'b0, '0, 1'b0, '0, got);
        3: bus_op("rnd_st", 1'b0, 1'b1, '0, 1'b0, '0, got);
        4: bus_op("rnd_wr", 1'b1, 1'b1, wd, 1'b0, '0, got);
        default: bus_op("rnd_mix", 1'($urandom), 1'($urandom), wd, 1'b1,
                        BITS'($urandom), got);
      endcase
    end
    bus_op("end_st", 1'b0, 1'b1, '0, 1'b0, '0, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning received character width (1..8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-003 SHALL have port i_wb_clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port i_wb_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_rx_done  input  1  one-cycle pulse from the receiver: character complete.
REQ-006 SHALL have port i_rx_data  input  BITS  receiver character, valid while i_rx_done=1.
REQ-007 SHALL have port i_rx_active  input  1  receiver mid-frame indication.
REQ-008 SHALL have port i_wb_cyc  input  1  bus cycle request.
REQ-009 SHALL have port i_wb_we  input  1  1=write, 0=read.
REQ-010 SHALL have port i_wb_adr  input  1  0=DATA register, 1=STATUS/CTRL register.
REQ-011 SHALL have port i_wb_dat  input  32  write data.
REQ-012 SHALL have port o_wb_rdt  output  32  read data, valid with o_wb_ack.
REQ-013 SHALL have port o_wb_ack  output  1  one-cycle transfer acknowledge.
REQ-014 SHALL have port o_irq  output  1  interrupt, present only per REQ-032.

Function
REQ-015 SHALL push i_rx_data into the FIFO on i_rx_done=1 when EN=1 and FIFO not full.
REQ-016 SHALL drop the character and set sticky OVR when i_rx_done=1, EN=1, FIFO full, and no pop in the same cycle.
REQ-017 SHALL accept the push without OVR when full and a pop occurs in the same cycle; count unchanged.
REQ-018 SHALL ignore i_rx_done entirely while EN=0 (no push, no OVR).
REQ-019 SHALL implement a bus FSM, states IDLE and ACK: IDLE->ACK when i_wb_cyc=1; ACK->IDLE unconditionally; o_wb_ack=1 only in ACK.
REQ-020 SHALL perform register side effects (pop, write) on the IDLE->ACK transition only, exactly once per cycle request.
REQ-021 SHALL return, on DATA read with FIFO non-empty, the head character zero-extended in o_wb_rdt[BITS-1:0] and pop it.
REQ-022 SHALL return 0 and not pop on DATA read with FIFO empty.
REQ-023 SHALL return on STATUS read: bit0 NE (not empty), bit1 FULL, bit2 OVR, bit3 i_rx_active, bits[8:4] count, bit16 EN, bit17 IE; others 0.
REQ-024 SHALL on STATUS write: bit2=1 clears OVR, bit16 loads EN, bit17 loads IE; other bits ignored.
REQ-025 SHALL ignore DATA writes (ack still given).
REQ-026 SHALL give OVR-set priority over OVR-clear when both occur in the same cycle.
REQ-027 SHALL keep count in log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
REQ-028 SHALL hold o_wb_rdt at 0 whenever o_wb_ack=0.

Reset
REQ-029 SHALL on i_wb_rst=1 clear FIFO pointers and count, OVR=0, IE=0, EN=1, FSM=IDLE, o_wb_ack=0, o_wb_rdt=0, o_irq=0.
REQ-030 SHALL discard any in-flight bus cycle and any coincident i_rx_done when reset is asserted mid-operation.
REQ-031 SHALL leave FIFO storage contents uninitialised (not observable while empty).

Configuration
REQ-032 SHALL compile o_irq logic only when UART_RX_IRQ_EN is defined: o_irq registered = IE & (NE | OVR), updated one cycle after the condition changes.
REQ-033 SHALL without UART_RX_IRQ_EN tie o_irq to 0 and read IE as 0 (writes ignored).

Structure
REQ-034 SHALL place register addresses, STATUS/CTRL bit positions and FSM state encodings in shared package uart_pkg.
REQ-035 SHALL implement storage/pointers in one sub-module uart_rx_fifo (push, pop, data, full, empty, count).

Verification
REQ-036 SHALL verify: three pulses 0x41,0x42,0x43 then three DATA reads -> rdt 0x41,0x42,0x43, then NE=0, count=0.
REQ-037 SHALL verify: DEPTH=4, five pulses without reads -> FULL=1, OVR=1, reads return first four; STATUS write 0x4 -> OVR=0.
REQ-038 SHALL verify: FIFO full, i_rx_done coincident with DATA-read pop -> OVR stays 0, count stays 4, new char read last.
REQ-039 SHALL verify: DATA read on empty FIFO -> rdt=0, one ack, count stays 0; EN=0 then pulse 0x55 -> count stays 0.
REQ-040 SHALL verify: with UART_RX_IRQ_EN, IE=1, one pulse -> o_irq=1 next cycle; pop -> o_irq=0; without macro o_irq=0 always.
REQ-041 SHALL verify: i_wb_rst asserted during ACK with count=2 -> next cycle ack=0, count=0, EN=1, OVR=0.
